// File: rtl/fetch_stage_ctrl.sv
// Fetch stage controller: PC register, next-PC selection, IF/ID pipeline
// register driven by the hazard unit, and saturating debug event counters.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PC_Write,
  input  logic             IF_ID_Write,
  input  logic             Flush,
  input  logic             Stall,
  input  logic             PCSource,
  input  logic [1:0]       Jump,
  input  logic [31:0]      BranchTarget,
  input  logic [31:0]      JumpTarget,
  input  logic [31:0]      JumpReg,
  input  logic [31:0]      InstrIn,
  output logic [31:0]      PC,
  output logic [31:0]      Instruction_ID,
  output logic [31:0]      PCPlus4_ID,
  output logic             Valid_ID,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [1:0]       JUMP_ABS = 2'd1;
  localparam logic [1:0]       JUMP_REG = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  // Sequential address wraps naturally modulo 2^32.
  assign pc_plus4 = pc_q + 32'd4;
  assign PC       = pc_q;

  // Next-PC select: taken branch beats any jump; reserved jump code falls through to sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (PCSource) begin
      next_pc = BranchTarget;
    end else begin
      case (Jump)
        JUMP_ABS: next_pc = JumpTarget;
        JUMP_REG: next_pc = JumpReg;
        default:  next_pc = pc_plus4;
      endcase
    end
  end

  // PC register: advances only when the hazard unit permits it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (PC_Write) begin
      pc_q <= next_pc;
    end
  end

  // IF/ID register: flush inserts a bubble even when the write enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      Instruction_ID <= 32'h0000_0000;
      PCPlus4_ID     <= 32'h0000_0000;
      Valid_ID       <= 1'b0;
    end else if (Flush) begin
      Instruction_ID <= 32'h0000_0000;
      PCPlus4_ID     <= 32'h0000_0000;
      Valid_ID       <= 1'b0;
    end else if (IF_ID_Write) begin
      Instruction_ID <= InstrIn;
      PCPlus4_ID     <= pc_plus4;
      Valid_ID       <= 1'b1;
    end
  end

  // Stall event counter, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
    end else if (Stall && (StallCount != CNT_MAX)) begin
      StallCount <= StallCount + CNT_ONE;
    end
  end

  // Flush event counter, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      FlushCount <= '0;
    end else if (Flush && (FlushCount != CNT_MAX)) begin
      FlushCount <= FlushCount + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Scoreboard bench for fetch_stage_ctrl: the driver applies directed vectors
// and queues hand-computed post-edge state; a monitor pops and compares.
module tb_fetch_stage_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             Flush;
  logic             Stall;
  logic             PCSource;
  logic [1:0]       Jump;
  logic [31:0]      BranchTarget;
  logic [31:0]      JumpTarget;
  logic [31:0]      JumpReg;
  logic [31:0]      InstrIn;
  logic [31:0]      PC;
  logic [31:0]      Instruction_ID;
  logic [31:0]      PCPlus4_ID;
  logic             Valid_ID;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
    int          sc;
    int          fc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] I0 = 32'h2008_0005;
  localparam logic [31:0] I1 = 32'h8C09_0000;
  localparam logic [31:0] I2 = 32'h0123_4567;

  fetch_stage_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .Flush(Flush), .Stall(Stall), .PCSource(PCSource), .Jump(Jump),
    .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .JumpReg(JumpReg),
    .InstrIn(InstrIn), .PC(PC), .Instruction_ID(Instruction_ID),
    .PCPlus4_ID(PCPlus4_ID), .Valid_ID(Valid_ID),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every cycle the DUT presents post-edge state, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", PC, e.pc);
        chk("instruction_id", Instruction_ID, e.ins);
        chk("pcplus4_id", PCPlus4_ID, e.p4);
        chk("valid_id", {31'd0, Valid_ID}, {31'd0, e.v});
        chk("stall_count", {28'd0, StallCount}, e.sc);
        chk("flush_count", {28'd0, FlushCount}, e.fc);
      end
    end
  end

  // One clock of stimulus: inputs are already set; expectation is pushed just after the edge.
  task automatic tick(input logic [31:0] e_pc, input logic [31:0] e_ins, input logic [31:0] e_p4,
                      input logic e_v, input int e_sc, input int e_fc);
    exp_t e;
    @(posedge clk);
    #1;
    e.pc = e_pc; e.ins = e_ins; e.p4 = e_p4; e.v = e_v; e.sc = e_sc; e.fc = e_fc;
    exp_q.push_back(e);
  endtask

  task automatic set_ctl(input logic rst, input logic pw, input logic iw, input logic fl,
                         input logic st, input logic ps, input logic [1:0] jp);
    reset = rst; PC_Write = pw; IF_ID_Write = iw; Flush = fl; Stall = st;
    PCSource = ps; Jump = jp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    BranchTarget = 32'h0; JumpTarget = 32'h0; JumpReg = 32'h0; InstrIn = I0;
    set_ctl(1, 1, 1, 0, 0, 0, 2'd0);

    // reset held two cycles
    tick(32'h0, 32'h0, 32'h0, 0, 0, 0);
    tick(32'h0, 32'h0, 32'h0, 0, 0, 0);

    // free run
    set_ctl(0, 1, 1, 0, 0, 0, 2'd0);
    tick(32'h4, I0, 32'h4, 1, 0, 0);
    tick(32'h8, I0, 32'h8, 1, 0, 0);

    // load-use stall at PC 8
    set_ctl(0, 0, 0, 0, 1, 0, 2'd0);
    tick(32'h8, I0, 32'h8, 1, 1, 0);
    set_ctl(0, 1, 1, 0, 0, 0, 2'd0); InstrIn = I1;
    tick(32'hC, I1, 32'hC, 1, 1, 0);

    // taken branch with flush, IF_ID_Write low
    BranchTarget = 32'h40;
    set_ctl(0, 1, 0, 1, 0, 1, 2'd0);
    tick(32'h40, 32'h0, 32'h0, 0, 1, 1);
    set_ctl(0, 1, 1, 0, 0, 0, 2'd0); InstrIn = I2;
    tick(32'h44, I2, 32'h44, 1, 1, 1);

    // branch beats jump
    BranchTarget = 32'h80; JumpTarget = 32'h100; JumpReg = 32'h200;
    set_ctl(0, 1, 1, 0, 0, 1, 2'd1);
    tick(32'h80, I2, 32'h48, 1, 1, 1);
    set_ctl(0, 1, 1, 0, 0, 0, 2'd2);
    tick(32'h200, I2, 32'h84, 1, 1, 1);
    set_ctl(0, 1, 1, 0, 0, 0, 2'd1);
    tick(32'h100, I2, 32'h204, 1, 1, 1);
    set_ctl(0, 1, 1, 0, 0, 0, 2'd3);
    tick(32'h104, I2, 32'h104, 1, 1, 1);

    // PC_Write low holds PC despite a jump request
    set_ctl(0, 0, 1, 0, 0, 0, 2'd1);
    tick(32'h104, I2, 32'h108, 1, 1, 1);

    // simultaneous stall and flush
    set_ctl(0, 0, 0, 1, 1, 0, 2'd0);
    tick(32'h104, 32'h0, 32'h0, 0, 2, 2);
    // IF/ID hold keeps the bubble while PC advances
    set_ctl(0, 1, 0, 0, 0, 0, 2'd0);
    tick(32'h108, 32'h0, 32'h0, 0, 2, 2);

    // mid-sequence reset with stall/flush active
    set_ctl(1, 1, 1, 1, 1, 1, 2'd1);
    tick(32'h0, 32'h0, 32'h0, 0, 0, 0);
    set_ctl(0, 1, 1, 0, 0, 0, 2'd0); InstrIn = I0;
    tick(32'h4, I0, 32'h4, 1, 0, 0);

    // stall counter saturation
    set_ctl(0, 0, 0, 0, 1, 0, 2'd0);
    for (int i = 1; i <= 20; i++) begin
      tick(32'h4, I0, 32'h4, 1, (i > 15) ? 15 : i, 0);
    end

    // flush counter saturation
    set_ctl(0, 0, 0, 1, 0, 0, 2'd0);
    for (int i = 1; i <= 18; i++) begin
      tick(32'h4, 32'h0, 32'h0, 0, 15, (i > 15) ? 15 : i);
    end

    // PC wrap through 32'hFFFF_FFFC
    JumpTarget = 32'hFFFF_FFFC; InstrIn = I1;
    set_ctl(0, 1, 1, 0, 0, 0, 2'd1);
    tick(32'hFFFF_FFFC, I1, 32'h8, 1, 15, 15);
    set_ctl(0, 1, 1, 0, 0, 0, 2'd0);
    tick(32'h0, I1, 32'h0, 1, 15, 15);
    tick(32'h4, I1, 32'h4, 1, 15, 15);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
